// File: rtl/axis_master_pkg.sv
// Shared types and defaults for the axis_master AXI4-Stream packet source.
// Optional send-while-busy queuing is enabled by defining AXIS_MASTER_PENDING_EN.
package axis_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_BURST_LEN = 1;

    // Counter width able to hold every beat index 0..burst_len.
    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage : axis_master_pkg

// File: rtl/axis_master_beat_cnt.sv
// Beat index counter for one packet; flags the final beat and the beat before it.
module axis_master_beat_cnt
    import axis_master_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int CNT_W     = cnt_width(BURST_LEN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,
    output logic             next_last_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign last_o      = (cnt_q == LAST_IDX);
    assign next_last_o = (cnt_d == LAST_IDX);

endmodule : axis_master_beat_cnt

// File: rtl/axis_master.sv
// AXI4-Stream master: a send strobe captures a word, then BURST_LEN incrementing beats go out.
// Define AXIS_MASTER_PENDING_EN to queue one send that arrives while a packet is in flight.
module axis_master
    import axis_master_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic [DATA_W-1:0] data,
    input  logic              send,
    input  logic              tready,
    output logic              tvalid,
    output logic              tlast,
    output logic [DATA_W-1:0] tdata,
    output logic              finish
);

    localparam int CNT_W = cnt_width(BURST_LEN);

    state_t            state_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic [DATA_W-1:0] tdata_q;
    logic              finish_q;
    logic [DATA_W-1:0] base_q;

`ifdef AXIS_MASTER_PENDING_EN
    logic              pending_q;
    logic [DATA_W-1:0] hold_q;
`endif

    logic              start_d;
    logic [DATA_W-1:0] start_word_d;
    logic [DATA_W-1:0] beat_data_d;
    logic              handshake;
    logic [CNT_W-1:0]  beat_cnt;
    logic              beat_last;
    logic              beat_next_last;

    assign handshake = tvalid_q && tready;

    axis_master_beat_cnt #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_beat_cnt (
        .clk_i       (aclk),
        .rst_i       (areset_n),
        .clr_i       (state_q != XFER),
        .inc_i       ((state_q == XFER) && handshake && !beat_last),
        .cnt_o       (beat_cnt),
        .last_o      (beat_last),
        .next_last_o (beat_next_last)
    );

    assign beat_data_d = base_q + DATA_W'(beat_cnt) + DATA_W'(1);

    // A packet starts from IDLE on send, or straight out of DONE when a send is queued.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        start_d      = (state_q == IDLE) && send;
        start_word_d = data;
`ifdef AXIS_MASTER_PENDING_EN
        if (state_q == DONE) begin
            start_d = pending_q || send;
            if (!send) begin
                start_word_d = hold_q;
            end
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset_n) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            finish_q <= 1'b0;
`ifdef AXIS_MASTER_PENDING_EN
            pending_q <= 1'b0;
`endif
        end else begin
            finish_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_d) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= start_word_d;
                        tlast_q  <= (BURST_LEN == 1);
                        state_q  <= XFER;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                XFER: begin
                    if (handshake) begin
                        if (beat_last) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            finish_q <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            tdata_q  <= beat_data_d;
                            tlast_q  <= beat_next_last;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef AXIS_MASTER_PENDING_EN
            // A send in DONE is consumed on the same edge, so only XFER leaves it pending.
            if (state_q == DONE) begin
                pending_q <= 1'b0;
            end else if ((state_q == XFER) && send) begin
                pending_q <= 1'b1;
            end
`endif
        end
    end

    // NOTE: pure data registers carry no reset; their contents are only used
    // after a start or pending flag (both reset) qualifies them.
    always_ff @(posedge aclk) begin
        if (start_d) begin
            base_q <= start_word_d;
        end
`ifdef AXIS_MASTER_PENDING_EN
        if (send && (state_q != IDLE)) begin
            hold_q <= data;
        end
`endif
    end

    assign tvalid = tvalid_q;
    assign tlast  = tlast_q;
    assign tdata  = tdata_q;
    assign finish = finish_q;

endmodule : axis_master

// File: tb/tb_axis_master.sv
// Self-checking bench for axis_master: one single-beat and one four-beat instance,
// directed scenarios plus randomized packets checked against a beat-list model.
module tb_axis_master;

    localparam int DATA_W = 32;
    localparam int BUDGET = 400;

    logic              clk = 1'b0;
    logic              areset_n;
    logic [DATA_W-1:0] data_a, data_b;
    logic              send_a, send_b;
    logic              tready_a, tready_b;
    logic              tvalid_a, tvalid_b;
    logic              tlast_a, tlast_b;
    logic [DATA_W-1:0] tdata_a, tdata_b;
    logic              finish_a, finish_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_master #(.DATA_W(DATA_W), .BURST_LEN(1)) dut_a (
        .aclk(clk), .areset_n(areset_n), .data(data_a), .send(send_a), .tready(tready_a),
        .tvalid(tvalid_a), .tlast(tlast_a), .tdata(tdata_a), .finish(finish_a)
    );

    axis_master #(.DATA_W(DATA_W), .BURST_LEN(4)) dut_b (
        .aclk(clk), .areset_n(areset_n), .data(data_b), .send(send_b), .tready(tready_b),
        .tvalid(tvalid_b), .tlast(tlast_b), .tdata(tdata_b), .finish(finish_b)
    );

    function automatic int burst_of(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    function automatic logic o_tvalid(input int s);
        return (s == 0) ? tvalid_a : tvalid_b;
    endfunction

    function automatic logic o_tlast(input int s);
        return (s == 0) ? tlast_a : tlast_b;
    endfunction

    function automatic logic o_finish(input int s);
        return (s == 0) ? finish_a : finish_b;
    endfunction

    function automatic logic [DATA_W-1:0] o_tdata(input int s);
        return (s == 0) ? tdata_a : tdata_b;
    endfunction

    task automatic set_send(input int s, input logic v, input logic [DATA_W-1:0] d);
        if (s == 0) begin send_a = v; data_a = d; end
        else        begin send_b = v; data_b = d; end
    endtask

    task automatic set_ready(input int s, input logic v);
        if (s == 0) tready_a = v;
        else        tready_b = v;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int s, input string tag);
        check({tag, " tvalid"}, 32'(o_tvalid(s)), 32'd0);
        check({tag, " tlast"},  32'(o_tlast(s)),  32'd0);
        check({tag, " finish"}, 32'(o_finish(s)), 32'd0);
    endtask

    // Called on a negedge; the packet is captured on the following posedge.
    task automatic send_pkt(input int s, input logic [DATA_W-1:0] d);
        set_send(s, 1'b1, d);
        @(negedge clk);
        set_send(s, 1'b0, $urandom);
    endtask

    // Model: beat k of a packet is base+k, tlast only on beat burst-1, finish the
    // cycle after the last handshake. Stalled beats must hold their value.
    task automatic drain(input int s, input logic [DATA_W-1:0] base, input int pct, input int stall_n);
        int   bl;
        int   k;
        int   cyc;
        logic rdy;
        bl  = burst_of(s);
        k   = 0;
        cyc = 0;
        while (k < bl && cyc < BUDGET) begin
            check($sformatf("s%0d beat%0d tvalid", s, k), 32'(o_tvalid(s)), 32'd1);
            check($sformatf("s%0d beat%0d tdata", s, k), o_tdata(s), base + DATA_W'(k));
            check($sformatf("s%0d beat%0d tlast", s, k), 32'(o_tlast(s)), 32'(k == bl - 1));
            check($sformatf("s%0d beat%0d finish", s, k), 32'(o_finish(s)), 32'd0);
            rdy = (cyc >= stall_n) && ($urandom_range(99) < pct);
            set_ready(s, rdy);
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        check($sformatf("s%0d beats within budget", s), 32'(k), 32'(bl));
        check($sformatf("s%0d done finish", s), 32'(o_finish(s)), 32'd1);
        check($sformatf("s%0d done tvalid", s), 32'(o_tvalid(s)), 32'd0);
        check($sformatf("s%0d done tlast", s), 32'(o_tlast(s)), 32'd0);
        set_ready(s, 1'($urandom_range(1)));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset_n = 1'b1;
        set_send(0, 1'b0, '0);
        set_send(1, 1'b0, '0);
        set_ready(0, 1'b0);
        set_ready(1, 1'b0);

        // Reset held for four cycles: all outputs quiet.
        repeat (4) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                check_idle(s, $sformatf("reset s%0d", s));
                check($sformatf("reset s%0d tdata", s), o_tdata(s), '0);
            end
        end
        areset_n = 1'b0;
        @(negedge clk);
        check_idle(0, "post-reset s0");
        check_idle(1, "post-reset s1");

        // Single beat held under 8 cycles of back-pressure, then accepted.
        send_pkt(0, 32'haaaa_bbbb);
        drain(0, 32'haaaa_bbbb, 100, 8);
        check_idle(0, "after pkt aaaabbbb");

        // Second single-beat packet, ready pulse after 5 cycles.
        send_pkt(0, 32'hcccc_dddd);
        drain(0, 32'hcccc_dddd, 100, 5);
        repeat (2) begin
            check_idle(0, "after pkt ccccdddd");
            @(negedge clk);
        end

        // Four beats back to back with tready held high.
        set_ready(1, 1'b1);
        send_pkt(1, 32'h0000_0010);
        drain(1, 32'h0000_0010, 100, 0);
        check_idle(1, "after burst 10");

        // Beat data wraps modulo 2^DATA_W.
        send_pkt(1, 32'hffff_fffe);
        drain(1, 32'hffff_fffe, 100, 0);

        // Send while a packet is in flight.
        send_pkt(1, 32'h0000_0100);
        set_send(1, 1'b1, 32'h1234_5678);
        set_ready(1, 1'b0);
        @(negedge clk);
        set_send(1, 1'b0, $urandom);
        drain(1, 32'h0000_0100, 100, 0);
`ifdef AXIS_MASTER_PENDING_EN
        drain(1, 32'h1234_5678, 100, 0);
`endif
        repeat (4) begin
            check_idle(1, "no extra packet");
            @(negedge clk);
        end

        // Reset in the middle of a stalled packet drops it without finish.
        send_pkt(1, 32'h0000_0500);
        set_ready(1, 1'b0);
        @(negedge clk);
        check("mid-reset pre tvalid", 32'(tvalid_b), 32'd1);
        areset_n = 1'b1;
        @(negedge clk);
        check_idle(1, "mid-reset");
        check("mid-reset tdata", tdata_b, '0);
        areset_n = 1'b0;
        @(negedge clk);
        check_idle(1, "after mid-reset");
        send_pkt(1, 32'h0000_0600);
        drain(1, 32'h0000_0600, 100, 0);

        // Randomized packets with random back-pressure and idle gaps.
        for (int i = 0; i < 12; i++) begin
            for (int s = 0; s < 2; s++) begin
                logic [DATA_W-1:0] d;
                repeat ($urandom_range(3)) begin
                    set_ready(s, 1'($urandom_range(1)));
                    check_idle(s, $sformatf("gap s%0d", s));
                    @(negedge clk);
                end
                d = $urandom;
                send_pkt(s, d);
                drain(s, d, $urandom_range(30, 100), $urandom_range(3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_axis_master
